// File: rtl/trace_serializer.sv
// trace_serializer: queues STEP (and optionally MEMW) trace records and shifts them out as UART 8N1 bytes.
// Define TRACE_MEMWRITE_EN to also capture data-memory write records.
module trace_serializer #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        step_valid,
    input  logic [15:0] step_ip,
    input  logic [4:0]  step_opcode,
    input  logic [15:0] step_sp,
    input  logic [15:0] step_tos,
    input  logic        mem_write_enable,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_write_value,
    output logic        tx,
    output logic        busy,
    output logic [7:0]  overflow_count
);
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // Entry layout: bit 64 = MEMW flag, byte n of the record in bits [8n+7:8n].
    logic [64:0]   queue_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_ptr_plus1;
    logic [AW:0]   count;

    logic [64:0] step_rec;
    logic [64:0] memw_rec;
    logic        push_step;
    logic        push_memw;
    logic        acc_step;
    logic        acc_memw;
    logic [AW:0] free_slots;
    logic [1:0]  n_push;
    logic [1:0]  dropped;
    logic [8:0]  ovf_sum;
    logic        pop;

    logic [1:0]  state;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic [2:0]  byte_idx;
    logic [63:0] cur_rec;
    logic        cur_memw;
    logic [7:0]  cur_byte;
    logic        bit_done;
    logic        last_byte;

    assign push_step = step_valid;
    assign step_rec  = {1'b0, step_tos, step_sp, 3'b000, step_opcode, step_ip, 8'hA5};

`ifdef TRACE_MEMWRITE_EN
    assign push_memw = mem_write_enable;
    assign memw_rec  = {1'b1, 24'h000000, mem_write_value, mem_addr, 8'h5A};
`else
    logic unused_mem;
    assign unused_mem = ^{mem_write_enable, mem_addr, mem_write_value};
    assign push_memw  = 1'b0;
    assign memw_rec   = '0;
`endif

    // The active record lives in cur_rec, so its slot is released when it is loaded;
    // a same-cycle pop therefore counts as free space for the incoming pushes.
    always_comb begin
        free_slots = DEPTH_C - count + {{AW{1'b0}}, pop};
        acc_step   = push_step && (free_slots != '0);
        acc_memw   = push_memw && (free_slots > {{AW{1'b0}}, acc_step});
        n_push     = {1'b0, acc_step} + {1'b0, acc_memw};
        dropped    = {1'b0, push_step & ~acc_step} + {1'b0, push_memw & ~acc_memw};
        ovf_sum    = {1'b0, overflow_count} + {7'b0000000, dropped};
    end

    assign wr_ptr_plus1 = wr_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (acc_step) queue_mem[wr_ptr] <= step_rec;
        if (acc_memw) queue_mem[acc_step ? wr_ptr_plus1 : wr_ptr] <= memw_rec;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            overflow_count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count  <= count + (AW + 1)'(n_push) - {{AW{1'b0}}, pop};
            overflow_count <= ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
        end
    end

    assign bit_done  = (clk_cnt == BIT_LAST);
    assign cur_byte  = cur_rec[{byte_idx, 3'b000} +: 8];
    assign last_byte = (byte_idx == (cur_memw ? 3'd4 : 3'd7));
    assign pop       = (count != '0) &&
                       ((state == IDLE) || (state == STOP && bit_done && last_byte));
    assign busy      = (count != '0) || (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            cur_rec  <= '0;
            cur_memw <= 1'b0;
            tx       <= 1'b1;
        end else begin
            if (pop) begin
                cur_rec  <= queue_mem[rd_ptr][63:0];
                cur_memw <= queue_mem[rd_ptr][64];
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= START;
                        tx       <= 1'b0;
                        clk_cnt  <= '0;
                        byte_idx <= '0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= cur_byte[0];
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= cur_byte[bit_idx + 1'b1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        if (!last_byte) begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= START;
                            tx       <= 1'b0;
                        end else if (pop) begin
                            byte_idx <= '0;
                            state    <= START;
                            tx       <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trace_serializer.sv
// Self-checking bench for trace_serializer: UART monitor + timeline reference model + directed vectors.
// Honours TRACE_MEMWRITE_EN the same way as the design.
module tb_trace_serializer;
    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * C;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        step_valid = 1'b0;
    logic [15:0] step_ip = '0;
    logic [4:0]  step_opcode = '0;
    logic [15:0] step_sp = '0;
    logic [15:0] step_tos = '0;
    logic        mem_write_enable = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_write_value = '0;
    logic        tx;
    logic        busy;
    logic [7:0]  overflow_count;

    always #5 clk = ~clk;

    trace_serializer #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .step_valid(step_valid), .step_ip(step_ip), .step_opcode(step_opcode),
        .step_sp(step_sp), .step_tos(step_tos),
        .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
        .mem_write_value(mem_write_value),
        .tx(tx), .busy(busy), .overflow_count(overflow_count)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle time %0t)", name, act, exp, $time);
    endtask

    // Reference model: each accepted record occupies the wire for len*FRAME clocks,
    // starting one clock after capture or right when the previous record ends.
    // Records whose start lies in the future are the ones still sitting in the queue.
    typedef struct { logic [7:0] b; int t; } exp_byte_t;
    exp_byte_t   exp_q[$];
    int          starts[$];
    int          last_end = 0;
    int          ovf_model = 0;
    int          cyc = 0;
    logic [7:0]  bq[$];

    task automatic offer(input logic [7:0] bs[$]);
        int st;
        if (starts.size() < DEPTH) begin
            st = (cyc + 1 > last_end) ? cyc + 1 : last_end;
            last_end = st + bs.size() * FRAME;
            starts.push_back(st);
            foreach (bs[j]) exp_q.push_back('{bs[j], st + j * FRAME});
        end else if (ovf_model < 255) begin
            ovf_model++;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            starts.delete();
            last_end = 0;
            ovf_model = 0;
        end else begin
            cyc++;
            while (starts.size() > 0 && starts[0] <= cyc) void'(starts.pop_front());
            if (step_valid) begin
                bq.delete();
                bq.push_back(8'hA5);
                bq.push_back(step_ip[7:0]);  bq.push_back(step_ip[15:8]);
                bq.push_back({3'b000, step_opcode});
                bq.push_back(step_sp[7:0]);  bq.push_back(step_sp[15:8]);
                bq.push_back(step_tos[7:0]); bq.push_back(step_tos[15:8]);
                offer(bq);
            end
`ifdef TRACE_MEMWRITE_EN
            if (mem_write_enable) begin
                bq.delete();
                bq.push_back(8'h5A);
                bq.push_back(mem_addr[7:0]);        bq.push_back(mem_addr[15:8]);
                bq.push_back(mem_write_value[7:0]); bq.push_back(mem_write_value[15:8]);
                offer(bq);
            end
`endif
        end
    end

    // UART receiver: samples mid-bit, scores each byte and its start time.
    logic       mon_active = 1'b0;
    int         mon_t = 0;
    int         mon_start = 0;
    logic [7:0] mon_byte = '0;
    logic [7:0] rx_log[$];
    int         low_samples = 0;
    exp_byte_t  eb;

    always @(negedge clk) begin
        if (reset_n && tx == 1'b0) low_samples++;
        if (!reset_n) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx == 1'b0) begin
                mon_active = 1'b1;
                mon_t = 0;
                mon_start = cyc;
            end
        end else begin
            mon_t++;
        end
        if (reset_n && mon_active) begin
            if (mon_t % C == C / 2) begin
                if (mon_t / C == 0) check("start_bit", {63'd0, tx}, 64'd0);
                else if (mon_t / C <= 8) mon_byte[mon_t / C - 1] = tx;
                else begin
                    check("stop_bit", {63'd0, tx}, 64'd1);
                    rx_log.push_back(mon_byte);
                    check("rx_byte_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        eb = exp_q.pop_front();
                        check("rx_byte_value", {56'd0, mon_byte}, {56'd0, eb.b});
                        check("rx_byte_time", 64'(mon_start), 64'(eb.t));
                    end
                end
            end
            if (mon_t == FRAME - 1) mon_active = 1'b0;
        end
    end

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while ((busy || mon_active) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, {63'd0, busy | mon_active}, 64'd0);
        check({name, "_all_bytes_seen"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_random_fields();
        step_ip = 16'($urandom); step_opcode = 5'($urandom);
        step_sp = 16'($urandom); step_tos = 16'($urandom);
        mem_addr = 16'($urandom); mem_write_value = 16'($urandom);
    endtask

    typedef struct {
        logic [15:0] ip; logic [4:0] op; logic [15:0] sp; logic [15:0] tos;
        logic [63:0] exp;   // expected bytes, first byte in [7:0]
    } vec_t;
    vec_t vecs[4];

    logic [7:0] exp34[$];
    logic [63:0] rx_word;
    int n;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h0012, 5'h05, 16'h3FF0, 16'h0007, 64'h00073FF0050012A5};
        vecs[1] = '{16'hFFFF, 5'h1F, 16'h8000, 16'h1234, 64'h123480001FFFFFA5};
        vecs[2] = '{16'h0000, 5'h00, 16'h0000, 16'h0000, 64'h00000000000000A5};
        vecs[3] = '{16'hABCD, 5'h10, 16'h0102, 16'hFEDC, 64'hFEDC010210ABCDA5};

        #2 reset_n = 1'b0;
        #1;
        check("reset_tx", {63'd0, tx}, 64'd1);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_ovf", {56'd0, overflow_count}, 64'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed STEP records: latency, frame length, byte content
        foreach (vecs[i]) begin
            rx_log.delete();
            step_ip = vecs[i].ip; step_opcode = vecs[i].op;
            step_sp = vecs[i].sp; step_tos = vecs[i].tos;
            step_valid = 1'b1;
            @(posedge clk); #1 step_valid = 1'b0;
            check("busy_after_capture", {63'd0, busy}, 64'd1);
            check("tx_before_launch", {63'd0, tx}, 64'd1);
            @(posedge clk); #1;
            check("tx_start_at_launch", {63'd0, tx}, 64'd0);
            n = 0;
            while (busy && n < 2000) begin
                @(posedge clk); #1;
                n++;
            end
            check("record_clocks", 64'(n), 64'(8 * FRAME));
            @(negedge clk);
            check("vec_byte_count", 64'(rx_log.size()), 64'd8);
            rx_word = '0;
            foreach (rx_log[j]) if (j < 8) rx_word[8*j +: 8] = rx_log[j];
            check("vec_bytes", rx_word, vecs[i].exp);
            @(posedge clk); #1;
        end

        // Six back-to-back pulses: one shifting, four queued, one dropped
        rx_log.delete();
        for (int i = 0; i < 6; i++) begin
            set_random_fields();
            step_valid = 1'b1;
            @(posedge clk); #1;
        end
        step_valid = 1'b0;
        check("burst_overflow", {56'd0, overflow_count}, 64'd1);
        wait_idle("burst", 3000);
        check("burst_byte_count", 64'(rx_log.size()), 64'd40);
        check("burst_overflow_model", {56'd0, overflow_count}, 64'(ovf_model));

        // Coincident STEP and memory write
        rx_log.delete();
        step_ip = 16'h0001; step_opcode = 5'h11; step_sp = 16'h0100; step_tos = 16'h0000;
        mem_addr = 16'h0200; mem_write_value = 16'hBEEF;
        step_valid = 1'b1; mem_write_enable = 1'b1;
        @(posedge clk); #1;
        step_valid = 1'b0; mem_write_enable = 1'b0;
        exp34.delete();
        exp34.push_back(8'hA5); exp34.push_back(8'h01); exp34.push_back(8'h00);
        exp34.push_back(8'h11); exp34.push_back(8'h00); exp34.push_back(8'h01);
        exp34.push_back(8'h00); exp34.push_back(8'h00);
`ifdef TRACE_MEMWRITE_EN
        exp34.push_back(8'h5A); exp34.push_back(8'h00); exp34.push_back(8'h02);
        exp34.push_back(8'hEF); exp34.push_back(8'hBE);
`endif
        wait_idle("coincident", 3000);
        check("coincident_byte_count", 64'(rx_log.size()), 64'(exp34.size()));
        foreach (exp34[j])
            if (j < rx_log.size()) check("coincident_byte", {56'd0, rx_log[j]}, {56'd0, exp34[j]});

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            set_random_fields();
            step_valid = ($urandom_range(0, 99) < 1);
            mem_write_enable = ($urandom_range(0, 99) < 1);
            @(posedge clk); #1;
        end
        step_valid = 1'b0; mem_write_enable = 1'b0;
        check("random_overflow", {56'd0, overflow_count}, 64'(ovf_model));
        wait_idle("random", 8000);

        // Reset during DATA of the third byte
        set_random_fields();
        step_valid = 1'b1;
        @(posedge clk); #1 step_valid = 1'b0;
        @(posedge clk); #1;
        repeat (2 * FRAME + C + 3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("midframe_reset_tx", {63'd0, tx}, 64'd1);
        check("midframe_reset_busy", {63'd0, busy}, 64'd0);
        check("midframe_reset_ovf", {56'd0, overflow_count}, 64'd0);
        @(posedge clk); #1 step_valid = 1'b1;
        @(posedge clk); #1 step_valid = 1'b0;
        reset_n = 1'b1;
        low_samples = 0;
        repeat (200) @(negedge clk);
        check("post_reset_tx_quiet", 64'(low_samples), 64'd0);
        check("post_reset_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        rx_log.delete();
        set_random_fields();
        step_valid = 1'b1;
        @(posedge clk); #1 step_valid = 1'b0;
        wait_idle("post_reset", 2000);
        check("post_reset_bytes", 64'(rx_log.size()), 64'd8);

        // Saturating overflow counter
        for (int i = 0; i < 400; i++) begin
            set_random_fields();
            step_valid = 1'b1;
            @(posedge clk); #1;
            if (i == 100) check("ovf_midway", {56'd0, overflow_count}, 64'(ovf_model));
        end
        step_valid = 1'b0;
        check("ovf_saturated", {56'd0, overflow_count}, 64'd255);
        check("ovf_model_saturated", {56'd0, overflow_count}, 64'(ovf_model));
        wait_idle("saturate", 5000);
        check("ovf_holds", {56'd0, overflow_count}, 64'd255);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
